// File: rtl/counter3bit_monitor.sv
// counter3bit_monitor: decodes 3-bit counter transitions into INC/ROT/SET/CLR/ERR.
// Define COUNTER3BIT_MON_STATS_EN to build the per-class statistics counters.
module counter3bit_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_valid,
    input  logic [2:0]       count_in,
    input  logic             clear,
    output logic             op_valid,
    output logic [2:0]       op,
    output logic             err,
    output logic             fault,
    output logic [CNT_W-1:0] inc_cnt,
    output logic [CNT_W-1:0] rot_cnt,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_ROT  = 3'd2;
    localparam logic [2:0] OP_SET  = 3'd3;
    localparam logic [2:0] OP_CLR  = 3'd4;
    localparam logic [2:0] OP_ERR  = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] prev;
    logic [2:0] dec;
    logic       do_dec;

    // First match wins: 7->0 is INC, 0->0 and 7->7 are ROT.
    always_comb begin
        dec = OP_ERR;
        if (count_in == prev + 3'd1)
            dec = OP_INC;
        else if (count_in == {prev[1:0], prev[2]})
            dec = OP_ROT;
        else if (count_in == 3'd7)
            dec = OP_SET;
        else if (count_in == 3'd0)
            dec = OP_CLR;
    end

    assign do_dec = sample_valid && !clear && (state != EMPTY);
    assign fault  = (state == FAULT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            prev     <= 3'd0;
            op_valid <= 1'b0;
            op       <= OP_NONE;
            err      <= 1'b0;
        end else if (clear) begin
            state    <= EMPTY;
            prev     <= 3'd0;
            op_valid <= 1'b0;
            op       <= OP_NONE;
            err      <= 1'b0;
        end else if (sample_valid) begin
            prev <= count_in;
            if (state == EMPTY) begin
                state    <= TRACK;
                op_valid <= 1'b0;
                err      <= 1'b0;
            end else begin
                op_valid <= 1'b1;
                op       <= dec;
                err      <= (dec == OP_ERR);
                if (dec == OP_ERR)
                    state <= FAULT;
            end
        end else begin
            op_valid <= 1'b0;
            err      <= 1'b0;
        end
    end

`ifdef COUNTER3BIT_MON_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_cnt <= '0;
            rot_cnt <= '0;
            set_cnt <= '0;
            clr_cnt <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            inc_cnt <= '0;
            rot_cnt <= '0;
            set_cnt <= '0;
            clr_cnt <= '0;
            err_cnt <= '0;
        end else if (do_dec) begin
            unique case (dec)
                OP_INC:  inc_cnt <= sat_inc(inc_cnt);
                OP_ROT:  rot_cnt <= sat_inc(rot_cnt);
                OP_SET:  set_cnt <= sat_inc(set_cnt);
                OP_CLR:  clr_cnt <= sat_inc(clr_cnt);
                default: err_cnt <= sat_inc(err_cnt);
            endcase
        end
    end
`else
    logic unused_dec;
    assign unused_dec = do_dec;
    assign inc_cnt = '0;
    assign rot_cnt = '0;
    assign set_cnt = '0;
    assign clr_cnt = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_counter3bit_monitor.sv
// tb_counter3bit_monitor: directed vector table plus async-reset and
// post-reset sequences for counter3bit_monitor (CNT_W = 2).
module tb_counter3bit_monitor;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sample_valid = 1'b0;
    logic [2:0]       count_in = 3'd0;
    logic             clear = 1'b0;
    logic             op_valid;
    logic [2:0]       op;
    logic             err;
    logic             fault;
    logic [CNT_W-1:0] inc_cnt, rot_cnt, set_cnt, clr_cnt, err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    counter3bit_monitor #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .count_in(count_in), .clear(clear), .op_valid(op_valid),
        .op(op), .err(err), .fault(fault), .inc_cnt(inc_cnt),
        .rot_cnt(rot_cnt), .set_cnt(set_cnt), .clr_cnt(clr_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       sv;
        logic [2:0] cin;
        logic       opv;
        logic [2:0] op;
        logic       er;
        logic       flt;
        logic [1:0] ic, rc, sc, cc, ec;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic clr, input logic sv,
                                input logic [2:0] cin, input logic opv,
                                input logic [2:0] o, input logic er,
                                input logic flt, input logic [1:0] ic,
                                input logic [1:0] rc, input logic [1:0] sc,
                                input logic [1:0] cc, input logic [1:0] ec);
        vec_t v;
        v.clr = clr; v.sv = sv; v.cin = cin; v.opv = opv; v.op = o;
        v.er = er; v.flt = flt; v.ic = ic; v.rc = rc; v.sc = sc;
        v.cc = cc; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic opv,
                             input logic [2:0] o, input logic er,
                             input logic flt, input logic [1:0] ic,
                             input logic [1:0] rc, input logic [1:0] sc,
                             input logic [1:0] cc, input logic [1:0] ec);
        logic [1:0] eic, erc, esc, ecc, eec;
`ifdef COUNTER3BIT_MON_STATS_EN
        eic = ic; erc = rc; esc = sc; ecc = cc; eec = ec;
`else
        eic = 2'd0; erc = 2'd0; esc = 2'd0; ecc = 2'd0; eec = 2'd0;
        if (ic + rc + sc + cc + ec > 15) $display("note: stats disabled");
`endif
        check({tag, ".op_valid"}, int'(op_valid), int'(opv));
        check({tag, ".op"}, int'(op), int'(o));
        check({tag, ".err"}, int'(err), int'(er));
        check({tag, ".fault"}, int'(fault), int'(flt));
        check({tag, ".inc_cnt"}, int'(inc_cnt), int'(eic));
        check({tag, ".rot_cnt"}, int'(rot_cnt), int'(erc));
        check({tag, ".set_cnt"}, int'(set_cnt), int'(esc));
        check({tag, ".clr_cnt"}, int'(clr_cnt), int'(ecc));
        check({tag, ".err_cnt"}, int'(err_cnt), int'(eec));
    endtask

    initial begin
        // clr sv cin | opv op er flt | inc rot set clr err
        tv.push_back(mk(0,1,3'd0, 0,3'd0,0,0, 0,0,0,0,0));
        tv.push_back(mk(0,1,3'd1, 1,3'd1,0,0, 1,0,0,0,0));
        tv.push_back(mk(0,1,3'd2, 1,3'd1,0,0, 2,0,0,0,0));
        tv.push_back(mk(0,1,3'd3, 1,3'd1,0,0, 3,0,0,0,0));
        tv.push_back(mk(0,0,3'd5, 0,3'd1,0,0, 3,0,0,0,0));
        tv.push_back(mk(1,0,3'd0, 0,3'd0,0,0, 0,0,0,0,0));
        tv.push_back(mk(0,1,3'd3, 0,3'd0,0,0, 0,0,0,0,0));
        tv.push_back(mk(0,1,3'd6, 1,3'd2,0,0, 0,1,0,0,0));
        tv.push_back(mk(0,1,3'd3, 1,3'd7,1,1, 0,1,0,0,1));
        tv.push_back(mk(0,1,3'd4, 1,3'd1,0,1, 1,1,0,0,1));
        tv.push_back(mk(0,0,3'd0, 0,3'd1,0,1, 1,1,0,0,1));
        tv.push_back(mk(1,1,3'd5, 0,3'd0,0,0, 0,0,0,0,0));
        tv.push_back(mk(0,1,3'd7, 0,3'd0,0,0, 0,0,0,0,0));
        tv.push_back(mk(0,1,3'd0, 1,3'd1,0,0, 1,0,0,0,0));
        tv.push_back(mk(0,1,3'd7, 1,3'd3,0,0, 1,0,1,0,0));
        tv.push_back(mk(0,1,3'd7, 1,3'd2,0,0, 1,1,1,0,0));
        tv.push_back(mk(0,1,3'd0, 1,3'd1,0,0, 2,1,1,0,0));
        tv.push_back(mk(0,1,3'd1, 1,3'd1,0,0, 3,1,1,0,0));
        tv.push_back(mk(0,1,3'd2, 1,3'd1,0,0, 3,1,1,0,0));
        tv.push_back(mk(0,1,3'd3, 1,3'd1,0,0, 3,1,1,0,0));
        tv.push_back(mk(0,1,3'd0, 1,3'd4,0,0, 3,1,1,1,0));
        tv.push_back(mk(0,1,3'd5, 1,3'd7,1,1, 3,1,1,1,1));
        tv.push_back(mk(0,1,3'd2, 1,3'd7,1,1, 3,1,1,1,2));
        tv.push_back(mk(0,1,3'd1, 1,3'd7,1,1, 3,1,1,1,3));
        tv.push_back(mk(0,1,3'd0, 1,3'd4,0,1, 3,1,1,2,3));
        tv.push_back(mk(0,1,3'd2, 1,3'd7,1,1, 3,1,1,2,3));

        #12;
        check_all("reset", 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            clear = tv[i].clr;
            sample_valid = tv[i].sv;
            count_in = tv[i].cin;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tv[i].opv, tv[i].op, tv[i].er,
                      tv[i].flt, tv[i].ic, tv[i].rc, tv[i].sc, tv[i].cc,
                      tv[i].ec);
        end

        // Asynchronous reset between edges while in FAULT with live counts.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        reset_n = 1'b1;
        sample_valid = 1'b1;
        count_in = 3'd4;
        clear = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst_first", 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        count_in = 3'd5;
        @(posedge clk);
        #1;
        check_all("post_rst_inc", 1, 3'd1, 0, 0, 1, 0, 0, 0, 0);

        @(negedge clk);
        count_in = 3'd2;
        @(posedge clk);
        #1;
        check_all("post_rst_err", 1, 3'd7, 1, 1, 1, 0, 0, 0, 1);

        @(negedge clk);
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_rst_idle", 0, 3'd7, 0, 1, 1, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
